sync_fifo_param: RTL and testbench

- Parametrised single-clock synchronous FIFO; next generation of the team's fixed 8-bit FIFO.
- Adds configurable width and depth, an occupancy count, and programmable almost-full/almost-empty thresholds.
- Adds single-cycle overflow/underflow error pulses and optional first-word-fall-through (FWFT) output.
- Sits between byte/word producers and consumers in the same clock domain.

---
 rtl/sync_fifo_param.sv | 82 ++++++++
 tb/tb_sync_fifo_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; otherwise reads have one cycle of latency.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, udf_q;
    logic             wr_acc, rd_acc;

    assign empty        = count_q == '0;
    assign full         = count_q == CW'(DEPTH);
    assign almost_empty = count_q <= CW'(AEMPTY_TH);
    assign almost_full  = count_q >= CW'(AFULL_TH);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_comb begin
        count_d = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                  (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            ovf_q   <= wr_en & ~wr_acc;
            udf_q   <= rd_en & ~rd_acc;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_o = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else if (rd_acc) data_q <= mem_q[rd_ptr_q];
    end

    assign data_o = data_q;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=4).
// Follows SYNC_FIFO_FWFT_EN so the same sequence checks either read mode.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_o;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0] count;
    int         vecs = 0;
    int         errs = 0;

    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_o(data_o), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        data_in = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Pops one word and checks it arrives with the mode's latency.
    task automatic pop(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        chk(tag, data_o, exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk(tag, data_o, exp);
`endif
    endtask

    initial begin
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_aempty", almost_empty, 1);
        chk("rst_afull", almost_full, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        reset = 1'b0;
        tick();

        // Mid-operation asynchronous reset
        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        chk("t1_count5", count, 5);
        pop("t1_pop", 8'h10);
        #3 reset = 1'b1;
        #1;
        chk("t1_async_count", count, 0);
        chk("t1_async_empty", empty, 1);
        chk("t1_async_data", data_o, 0);
        reset = 1'b0;
        tick();
        push(8'h77);
        chk("t1_post_count", count, 1);
        pop("t1_post_data", 8'h77);
        chk("t1_post_empty", empty, 1);

        // Fill, overflow, drain, underflow
        for (int i = 0; i < 16; i++) begin
            chk("t2_full_early", full, 0);
            push(8'h35 + 8'(i));
        end
        chk("t2_full", full, 1);
        chk("t2_count16", count, 16);
        chk("t2_no_ovf", overflow, 0);
        wr_en = 1'b1;
        data_in = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("t2_ovf_pulse", overflow, 1);
        chk("t2_ovf_count", count, 16);
        tick();
        chk("t2_ovf_once", overflow, 0);
        for (int i = 0; i < 16; i++) pop("t2_drain", 8'h35 + 8'(i));
        chk("t2_empty", empty, 1);
        chk("t2_count0", count, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t2_udf_pulse", underflow, 1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("t2_udf_data", data_o, 8'h00);
`else
        chk("t2_udf_hold", data_o, 8'h44);
`endif
        tick();
        chk("t2_udf_once", underflow, 0);

        // Thresholds
        for (int i = 0; i < 11; i++) push(8'h50 + 8'(i));
        chk("t3_afull_11", almost_full, 0);
        push(8'h5B);
        chk("t3_afull_12", almost_full, 1);
        chk("t3_count12", count, 12);
        for (int i = 0; i < 7; i++) pop("t3_pop", 8'h50 + 8'(i));
        chk("t3_count5", count, 5);
        chk("t3_aempty_5", almost_empty, 0);
        chk("t3_afull_5", almost_full, 0);
        pop("t3_pop", 8'h57);
        chk("t3_aempty_4", almost_empty, 1);
        for (int i = 8; i < 12; i++) pop("t3_pop", 8'h50 + 8'(i));
        chk("t3_empty", empty, 1);

        // Wrap-around with interleaved single pairs
        for (int i = 0; i < 40; i++) begin
            push(8'h80 + 8'(i));
            chk("t4_count1", count, 1);
            pop("t4_data", 8'h80 + 8'(i));
            chk("t4_count0", count, 0);
            chk("t4_no_err", {overflow, underflow}, 0);
        end

        // Simultaneous read+write when full
        for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
`ifdef SYNC_FIFO_FWFT_EN
        chk("t5_head", data_o, 8'hC0);
`endif
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 8'hEE;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("t5_full_count", count, 16);
        chk("t5_full_no_ovf", overflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t5_head", data_o, 8'hC0);
`endif
        for (int i = 1; i < 16; i++) pop("t5_older", 8'hC0 + 8'(i));
        pop("t5_new_last", 8'hEE);
        chk("t5_drained", empty, 1);

        // Simultaneous read+write when empty
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 8'h3C;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("t5_empty_count", count, 1);
        chk("t5_empty_udf", underflow, 1);
        tick();
        chk("t5_udf_once", underflow, 0);
        pop("t5_empty_data", 8'h3C);

`ifdef SYNC_FIFO_FWFT_EN
        // Fall-through of a single word
        push(8'hA5);
        chk("t6_fwft_data", data_o, 8'hA5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t6_fwft_empty", empty, 1);
        chk("t6_fwft_zero", data_o, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
